// File: rtl/fb_rect_fill_writer.sv
// rtl/fb_rect_fill_writer.sv - clipped rectangle fill engine writing a 16bpp packed-pair framebuffer
// Optional paired 32-bit writes: define FB_RECT_PAIR_WRITE_EN.
module fb_rect_fill_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x0,
  input  logic [9:0]        cmd_x1,
  input  logic [8:0]        cmd_y0,
  input  logic [8:0]        cmd_y1,
  input  logic [15:0]       cmd_colour,
  input  logic              mem_grant,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_FILL, S_DONE} state_t;

  localparam logic [9:0]  X_LAST   = 10'(H_RES - 1);
  localparam logic [8:0]  Y_LAST   = 9'(V_RES - 1);
  localparam logic [10:0] H_RES_W  = 11'(H_RES);
  localparam logic [9:0]  V_RES_W  = 10'(V_RES);
  localparam logic [19:0] ROW_STEP = 20'(H_RES);

  state_t      state;
  logic [9:0]  x0_q, x1_q, x1c_q, cur_x;
  logic [8:0]  y0_q, y1_q, y1c_q, cur_y;
  logic [15:0] colour_q;
  logic [19:0] row_base;
  logic        fill_active;

  logic [9:0]  clip_x1;
  logic [8:0]  clip_y1;
  logic        clip_empty;
  logic [19:0] pix;
  logic        pair_ok;
  logic [10:0] next_x;
  logic        row_end;
  logic        last_row;
  logic [3:0]  be;

  assign clip_x1    = (x1_q > X_LAST) ? X_LAST : x1_q;
  assign clip_y1    = (y1_q > Y_LAST) ? Y_LAST : y1_q;
  assign clip_empty = (x0_q > clip_x1) || (y0_q > clip_y1) ||
                      ({1'b0, x0_q} >= H_RES_W) || ({1'b0, y0_q} >= V_RES_W);

  // Linear pixel index; the word holding it is index/2, low half for even x.
  assign pix = row_base + 20'(cur_x);

`ifdef FB_RECT_PAIR_WRITE_EN
  assign pair_ok = ~cur_x[0] && (cur_x < x1c_q);
`else
  assign pair_ok = 1'b0;
`endif

  assign next_x   = {1'b0, cur_x} + (pair_ok ? 11'd2 : 11'd1);
  assign row_end  = next_x > {1'b0, x1c_q};
  assign last_row = (cur_y == y1c_q);

  always_comb begin
    be = 4'b0000;
    if (pair_ok)      be = 4'b1111;
    else if (cur_x[0]) be = 4'b1100;
    else              be = 4'b0011;
  end

  // Strobes are gated by the live grant so a stalled cycle never writes.
  assign mem_write      = fill_active & mem_grant;
  assign mem_chipselect = fill_active & mem_grant;
  assign mem_byteenable = fill_active ? be : 4'b0000;
  assign mem_address    = ADDR_W'(pix >> 1);
  assign mem_writedata  = {colour_q, colour_q};
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      x1c_q       <= '0;
      y1c_q       <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      colour_q    <= '0;
      row_base    <= '0;
      fill_active <= 1'b0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            x0_q      <= cmd_x0;
            x1_q      <= cmd_x1;
            y0_q      <= cmd_y0;
            y1_q      <= cmd_y1;
            colour_q  <= cmd_colour;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_CLIP;
          end
        end
        S_CLIP: begin
          x1c_q    <= clip_x1;
          y1c_q    <= clip_y1;
          cur_x    <= x0_q;
          cur_y    <= y0_q;
          // The only multiply: the starting row; later rows step by addition.
          row_base <= 20'(y0_q) * ROW_STEP;
          if (clip_empty) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            fill_active <= 1'b1;
            state       <= S_FILL;
          end
        end
        S_FILL: begin
          if (mem_grant) begin
            if (row_end) begin
              cur_x    <= x0_q;
              cur_y    <= cur_y + 9'd1;
              row_base <= row_base + ROW_STEP;
              if (last_row) begin
                fill_active <= 1'b0;
                done        <= 1'b1;
                state       <= S_DONE;
              end
            end else begin
              cur_x <= next_x[9:0];
            end
          end
        end
        S_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
